// File: rtl/rdma_cq_collect_pkg.sv
// rdma_cq_collect_pkg: ACK record layout, region count and output-stage states shared by the CQ collector.
package rdma_cq_collect_pkg;
  localparam int N_REGIONS = 4;
  localparam int CQ_DEPTH_DEF = 32;
  localparam int PID_BITS = 6;
  localparam int VFID_BITS = 4;
  localparam int SSN_BITS = 24;
  typedef struct packed {
    logic rd;
    logic cmplt;
    logic [PID_BITS-1:0] pid;
    logic [VFID_BITS-1:0] vfid;
    logic [SSN_BITS-1:0] ssn;
  } rdma_ack_t;
  localparam int RDMA_ACK_BITS = $bits(rdma_ack_t);
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
  function automatic logic [VFID_BITS:0] ack_key(rdma_ack_t a);
    return {a.rd, a.vfid};
  endfunction
endpackage

// File: rtl/rdma_cq_fifo.sv
// rdma_cq_fifo: synchronous FIFO with power-of-two depth; pointers wrap by natural overflow.
module rdma_cq_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 32
) (
  input  logic                     nclk,
  input  logic                     nrst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  always_ff @(posedge nclk)
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  always_ff @(posedge nclk)
    if (nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/rdma_cq_collect.sv
// rdma_cq_collect: buffers RDMA ACKs into a completion queue with a registered output entry.
// Per-region rd/wr completion counters and err_vfid exist only when CQ_STATS_EN is defined.
module rdma_cq_collect #(
  parameter int N_REGIONS = rdma_cq_collect_pkg::N_REGIONS,
  parameter int CQ_DEPTH = rdma_cq_collect_pkg::CQ_DEPTH_DEF,
  parameter int CNT_BITS = 32
) (
  input  logic                                          nclk,
  input  logic                                          nrst,
  input  logic                                          s_ack_valid_i,
  output logic                                          s_ack_ready_o,
  input  logic [rdma_cq_collect_pkg::RDMA_ACK_BITS-1:0] s_ack_data_i,
  output logic                                          m_cq_valid_o,
  input  logic                                          m_cq_ready_i,
  output logic [rdma_cq_collect_pkg::RDMA_ACK_BITS-1:0] m_cq_data_o,
  output logic [N_REGIONS*CNT_BITS-1:0]                 cnt_rd_o,
  output logic [N_REGIONS*CNT_BITS-1:0]                 cnt_wr_o,
  input  logic [N_REGIONS-1:0]                          cnt_clr_i,
  output logic [$clog2(CQ_DEPTH):0]                     cq_fill_o,
  output logic                                          err_vfid_o
);
  import rdma_cq_collect_pkg::rdma_ack_t;
  import rdma_cq_collect_pkg::out_state_e;
  import rdma_cq_collect_pkg::OUT_EMPTY;
  import rdma_cq_collect_pkg::OUT_FULL;
  import rdma_cq_collect_pkg::RDMA_ACK_BITS;
  import rdma_cq_collect_pkg::VFID_BITS;
  import rdma_cq_collect_pkg::ack_key;
  localparam int AW = $clog2(CQ_DEPTH);
  out_state_e state_q;
  rdma_ack_t head, out_q;
  logic [RDMA_ACK_BITS-1:0] head_raw;
  logic [AW:0] count;
  logic push, pop, full, empty;
  assign s_ack_ready_o = !full;
  assign push = s_ack_valid_i && !full;
  assign pop = !empty && (state_q == OUT_EMPTY || m_cq_ready_i);
  assign m_cq_valid_o = state_q == OUT_FULL;
  assign m_cq_data_o = out_q;
  assign cq_fill_o = count + (AW+1)'(m_cq_valid_o);
  rdma_cq_fifo #(.W(RDMA_ACK_BITS), .DEPTH(CQ_DEPTH)) u_fifo (
    .nclk(nclk), .nrst(nrst), .push_i(push), .pop_i(pop), .wdata_i(s_ack_data_i),
    .rdata_o(head_raw), .count_o(count), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    head = rdma_ack_t'(head_raw);
    head.cmplt = 1'b1;
  end
  // pop only happens when the output entry is free or being consumed this cycle
  always_ff @(posedge nclk)
    if (nrst) begin
      state_q <= OUT_EMPTY;
      out_q <= '0;
    end else if (pop) begin
      state_q <= OUT_FULL;
      out_q <= head;
    end else if (m_cq_ready_i) begin
      state_q <= OUT_EMPTY;
    end
`ifdef CQ_STATS_EN
  logic [VFID_BITS-1:0] vfid;
  logic rd;
  logic err_q;
  assign {rd, vfid} = ack_key(rdma_ack_t'(s_ack_data_i));
  assign err_vfid_o = err_q;
  for (genvar i = 0; i < N_REGIONS; i++) begin : g_cnt
    logic [CNT_BITS-1:0] rd_q, wr_q;
    logic inc_rd, inc_wr;
    assign inc_rd = push && int'(vfid) == i && rd;
    assign inc_wr = push && int'(vfid) == i && !rd;
    // a clear coinciding with an increment leaves that counter at 1
    always_ff @(posedge nclk)
      if (nrst) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        rd_q <= cnt_clr_i[i] ? CNT_BITS'(inc_rd) : rd_q + CNT_BITS'(inc_rd && !(&rd_q));
        wr_q <= cnt_clr_i[i] ? CNT_BITS'(inc_wr) : wr_q + CNT_BITS'(inc_wr && !(&wr_q));
      end
    assign cnt_rd_o[i*CNT_BITS +: CNT_BITS] = rd_q;
    assign cnt_wr_o[i*CNT_BITS +: CNT_BITS] = wr_q;
  end
  always_ff @(posedge nclk)
    err_q <= nrst ? 1'b0 : err_q || (push && int'(vfid) >= N_REGIONS);
`else
  logic unused_clr;
  assign unused_clr = ^cnt_clr_i;
  assign cnt_rd_o = '0;
  assign cnt_wr_o = '0;
  assign err_vfid_o = 1'b0;
`endif
endmodule

// File: doc/rdma_cq_collect.md
# rdma_cq_collect

Completion-queue collector directly downstream of the RoCE stack's flow-control stage. It consumes the RDMA ACK stream (`rdma_ack_t`: rd, cmplt, pid, vfid, ssn), buffers completions in a FIFO, and presents them to the host writeback path. It also keeps per-region read and write completion counters for the control registers.

## Interface

Parameters:
- N_REGIONS, default N_REGIONS (package): number of vFPGA regions; sets the number of counter pairs.
- CQ_DEPTH, default 32: FIFO entries; power of two, at least 2.
- CNT_BITS, default 32: width of each completion counter.

Ports:
- nclk, in, 1: the single clock.
- nrst, in, 1: reset, synchronous, active-high.
- s_ack, metaIntf.s, rdma_ack_t: ACK input (valid/ready/data).
- m_cq, metaIntf.m, rdma_ack_t: completion output to host writeback.
- cnt_rd, out, N_REGIONS*CNT_BITS: read completions per region; region i occupies slice [i*CNT_BITS +: CNT_BITS].
- cnt_wr, out, N_REGIONS*CNT_BITS: write completions per region, same layout.
- cnt_clr, in, N_REGIONS: per-region clear pulse; clears both counters of that region.
- cq_fill, out, $clog2(CQ_DEPTH)+1: current FIFO occupancy.
- err_vfid, out, 1: sticky; set when an ACK arrives with vfid ≥ N_REGIONS.

## Operation

FIFO:
- Memory of CQ_DEPTH × RDMA_ACK_BITS, with wr_ptr, rd_ptr and count.
- s_ack.ready = (count < CQ_DEPTH). It is combinational from count only and never depends on m_cq.ready.
- Push when s_ack.valid & s_ack.ready.

Output stage: a registered output entry.
- State OUT_EMPTY: m_cq.valid = 0. If count > 0, load the FIFO head, pop, and go to OUT_FULL.
- State OUT_FULL: m_cq.valid = 1 and data is held stable until handshake.
  - Handshake with count > 0: reload from the head and pop in the same cycle; stay in OUT_FULL.
  - Handshake with count = 0: go to OUT_EMPTY.
- There is no bypass. An entry always passes through the FIFO.

Data handling:
- All fields pass through unchanged, except cmplt, which is forced to 1 on m_cq.
- The order of m_cq equals the acceptance order of s_ack.

Counters:
- On each push with vfid < N_REGIONS, increment cnt_rd[vfid] if rd = 1, otherwise cnt_wr[vfid].
- Counters saturate at all-ones.
- If cnt_clr[i] is asserted in the same cycle as an increment to region i, that counter becomes 1. The other counter of region i becomes 0.
- An ACK with vfid ≥ N_REGIONS is still queued and forwarded, but no counter changes and err_vfid is set. err_vfid clears only on reset.

cq_fill = count + (m_cq.valid ? 1 : 0).

## Timing

Reset values:
- m_cq.valid = 0, s_ack.ready = 1, all counters 0, cq_fill = 0, err_vfid = 0.
- Pointers and count are 0 and the output state is OUT_EMPTY.
- Reset mid-operation discards all buffered entries; nothing is replayed.

Latency and throughput:
- An ACK accepted at edge k appears with m_cq.valid high from edge k+2, when the output register is empty.
- Counters update at edge k+1 after acceptance.
- Sustained throughput is 1 entry/cycle when m_cq.ready is held high.

Boundary conditions:
- Full: with count = CQ_DEPTH, ready stays low in that cycle even if a pop occurs; ready rises the cycle after count drops.
- Simultaneous push and pop with 0 < count < CQ_DEPTH: count is unchanged.
- Pointers wrap modulo CQ_DEPTH.
- Handshake rule on m_cq: once valid is asserted it remains asserted with stable data until ready.

## Configuration

- CQ_STATS_EN defined: counters, cnt_clr and err_vfid are implemented as described.
- CQ_STATS_EN undefined:
  - Counter logic is removed; cnt_rd, cnt_wr and err_vfid are tied to 0 and cnt_clr is ignored.
  - FIFO and output behaviour are identical.

## Structure

- Shared package (lynxTypes): rdma_ack_t, RDMA_ACK_BITS, N_REGIONS and the default CQ_DEPTH constant CQ_DEPTH_DEF.
- One sub-module, `rdma_cq_fifo`: synchronous FIFO with push/pop/count/full/empty. The output stage and counters live in the top module.

## Test plan

- Single write ACK (vfid=1, pid=3, rd=0, ssn=0x10, cmplt=0) with m_cq.ready=1 → m_cq.valid at k+2 with identical data except cmplt=1; cnt_wr[1]=1; cq_fill back to 0.
- 40 back-to-back ACKs with m_cq.ready=0 and CQ_DEPTH=32:
  - s_ack.ready drops after 33 accepted (32 in FIFO + 1 in the output register); cq_fill=33.
  - Release ready → all 40 are delivered in order, then cq_fill=0.
- Read ACK to vfid=0 together with cnt_clr[0] in the same cycle, with cnt_rd[0]=5 and cnt_wr[0]=7 beforehand → cnt_rd[0]=1 and cnt_wr[0]=0.
- ACK with vfid=N_REGIONS → forwarded on m_cq; no counter changes; err_vfid=1 and it stays set.
- Reset asserted while 10 entries are queued and m_cq.valid=1 → next cycle m_cq.valid=0, cq_fill=0 and counters 0; after reset no stale entry appears.
- Random valid/ready toggling with 1000 ACKs → output sequence equals input sequence; per-region counters match the scoreboard; compile both with and without CQ_STATS_EN.
